// File: rtl/conv_addr_pkg.sv
// -----------------------------------------------------------------------------
// conv_addr_pkg
// Shared types and constant helpers for the sliding-window address generator.
//   scan_state_e : scan FSM encoding (IDLE, RUN, DONE)
//   col_max      : last reachable anchor offset along one axis
//   lane_offset  : address offset of lane k inside the window
// -----------------------------------------------------------------------------
package conv_addr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } scan_state_e;

   // Largest anchor position that still keeps the whole window inside the
   // image, rounded down to a multiple of the stride.
   function automatic int col_max(input int img, input int win, input int stride);
      return ((img - win) / stride) * stride;
   endfunction

   // Row-major offset of lane k (k = r*win_w + c) from the window anchor.
   function automatic int lane_offset(input int k, input int win_w, input int img_w);
      return (k % win_w) + (k / win_w) * img_w;
   endfunction

endpackage

// File: rtl/win_anchor_scan.sv
// -----------------------------------------------------------------------------
// win_anchor_scan
// Frame-scan FSM: walks the window anchor across the feature map in raster
// order, one step per accepted beat.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      begin a scan (IDLE only) / terminate a scan (any state)
//   base_addr         address of pixel (0,0), captured on an accepted start
//   pause, out_ready  stall request / consumer acceptance
//   out_valid         current window is being presented
//   anchor            address of the current window's top-left pixel
//   anchor_row/col    current anchor position in pixels
//   win_last          current window is the last one of the frame
//   busy, done        scan in progress / one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module win_anchor_scan
   import conv_addr_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int IMG_W  = 35,
   parameter int IMG_H  = 35,
   parameter int WIN_W  = 5,
   parameter int WIN_H  = 5,
   parameter int STRIDE = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              pause,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [ADDR_W-1:0] anchor,
   output logic [CNT_W-1:0]  anchor_row,
   output logic [CNT_W-1:0]  anchor_col,
   output logic              win_last,
   output logic              busy,
   output logic              done
);

   localparam int COL_MAX = col_max(IMG_W, WIN_W, STRIDE);
   localparam int ROW_MAX = col_max(IMG_H, WIN_H, STRIDE);

   localparam logic [CNT_W-1:0]  COL_MAX_C  = CNT_W'(COL_MAX);
   localparam logic [CNT_W-1:0]  ROW_MAX_C  = CNT_W'(ROW_MAX);
   localparam logic [CNT_W-1:0]  CNT_STEP   = CNT_W'(STRIDE);
   localparam logic [ADDR_W-1:0] COL_STEP_A = ADDR_W'(STRIDE);
   // Moving one anchor row down skips STRIDE full image rows.
   localparam logic [ADDR_W-1:0] ROW_STEP_A = ADDR_W'(STRIDE * IMG_W);

   scan_state_e       state_r, state_nxt_s;
   logic [CNT_W-1:0]  row_r, row_nxt_s;
   logic [CNT_W-1:0]  col_r, col_nxt_s;
   logic [ADDR_W-1:0] anchor_r, anchor_nxt_s;
   logic [ADDR_W-1:0] row_base_r, row_base_nxt_s;
   logic              run_s, accept_s, at_col_end_s, at_row_end_s;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Anchor position and address registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_r      <= {CNT_W{1'b0}};
         col_r      <= {CNT_W{1'b0}};
         anchor_r   <= {ADDR_W{1'b0}};
         row_base_r <= {ADDR_W{1'b0}};
      end else begin
         row_r      <= row_nxt_s;
         col_r      <= col_nxt_s;
         anchor_r   <= anchor_nxt_s;
         row_base_r <= row_base_nxt_s;
      end
   end

   // Output decode and next-state/next-anchor computation
   always_comb begin
      state_nxt_s    = state_r;
      row_nxt_s      = row_r;
      col_nxt_s      = col_r;
      anchor_nxt_s   = anchor_r;
      row_base_nxt_s = row_base_r;

      // Outputs depend only on registered state plus the pause/ready gate,
      // so abort never disturbs the beat being shown this cycle.
      run_s        = (state_r == RUN);
      at_col_end_s = (col_r == COL_MAX_C);
      at_row_end_s = (row_r == ROW_MAX_C);
      out_valid    = run_s & ~pause;
      accept_s     = out_valid & out_ready;
      win_last     = run_s & at_col_end_s & at_row_end_s;
      busy         = (state_r != IDLE);
      done         = (state_r == DONE);

      if (abort) begin
         state_nxt_s    = IDLE;
         row_nxt_s      = {CNT_W{1'b0}};
         col_nxt_s      = {CNT_W{1'b0}};
         anchor_nxt_s   = {ADDR_W{1'b0}};
         row_base_nxt_s = {ADDR_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_nxt_s    = RUN;
                  row_nxt_s      = {CNT_W{1'b0}};
                  col_nxt_s      = {CNT_W{1'b0}};
                  anchor_nxt_s   = base_addr;
                  row_base_nxt_s = base_addr;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            RUN: begin
               if (!accept_s) begin
                  state_nxt_s = RUN;
               end else if (!at_col_end_s) begin
                  col_nxt_s    = col_r + CNT_STEP;
                  anchor_nxt_s = anchor_r + COL_STEP_A;
               end else if (!at_row_end_s) begin
                  col_nxt_s      = {CNT_W{1'b0}};
                  row_nxt_s      = row_r + CNT_STEP;
                  row_base_nxt_s = row_base_r + ROW_STEP_A;
                  anchor_nxt_s   = row_base_r + ROW_STEP_A;
               end else begin
                  // Final window accepted: anchor holds for inspection.
                  state_nxt_s = DONE;
               end
            end
            DONE: begin
               state_nxt_s = IDLE;
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   assign anchor     = anchor_r;
   assign anchor_row = row_r;
   assign anchor_col = col_r;

endmodule

// File: rtl/conv_window_addr_gen.sv
// -----------------------------------------------------------------------------
// conv_window_addr_gen
// Sliding-window address generator: presents all WIN_W*WIN_H pixel addresses of
// the current window in parallel, one window per accepted beat.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      begin / terminate a frame scan
//   base_addr         address of pixel (0,0), captured on an accepted start
//   pause             stall; hides out_valid and holds the anchor
//   out_ready         consumer accepts the current window
//   out_valid         addr_out carries a valid window
//   addr_out          lane k=r*WIN_W+c = anchor + c + r*IMG_W
//   anchor_row/col    current anchor position in pixels
//   win_last          current window is the final one of the frame
//   busy, done        scan in progress / one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module conv_window_addr_gen
   import conv_addr_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int IMG_W  = 35,
   parameter int IMG_H  = 35,
   parameter int WIN_W  = 5,
   parameter int WIN_H  = 5,
   parameter int STRIDE = 1,
   parameter int CNT_W  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic [ADDR_W-1:0]             base_addr,
   input  logic                          pause,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [ADDR_W*WIN_W*WIN_H-1:0] addr_out,
   output logic [CNT_W-1:0]              anchor_row,
   output logic [CNT_W-1:0]              anchor_col,
   output logic                          win_last,
   output logic                          busy,
   output logic                          done
);

   localparam int LANES = WIN_W * WIN_H;

   logic [ADDR_W-1:0] anchor_s;

   win_anchor_scan #(
      .ADDR_W (ADDR_W),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .WIN_W  (WIN_W),
      .WIN_H  (WIN_H),
      .STRIDE (STRIDE),
      .CNT_W  (CNT_W)
   ) u_scan (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .base_addr  (base_addr),
      .pause      (pause),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .anchor     (anchor_s),
      .anchor_row (anchor_row),
      .anchor_col (anchor_col),
      .win_last   (win_last),
      .busy       (busy),
      .done       (done)
   );

   // Each lane is the registered anchor plus a compile-time offset, so
   // base_addr and out_ready never reach addr_out combinationally.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam logic [ADDR_W-1:0] LANE_OFF = ADDR_W'(lane_offset(k, WIN_W, IMG_W));
      assign addr_out[k*ADDR_W +: ADDR_W] = anchor_s + LANE_OFF;
   end

endmodule

// File: tb/tb_conv_window_addr_gen.sv
module tb_conv_window_addr_gen;

   typedef struct {
      int          row;
      int          col;
      logic [31:0] anc;
   } win_t;

   int total = 0;
   int bad   = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // default-parameter instance (35x35 image, 5x5 window, stride 1)
   logic          start = 1'b0, abort = 1'b0, pause = 1'b0, out_ready = 1'b0;
   logic [31:0]   base_addr = 32'h0;
   logic          out_valid, win_last, busy, done;
   logic [799:0]  addr_out;
   logic [15:0]   anchor_row, anchor_col;

   // stride-2 instance (8x8 image, 3x3 window)
   logic          s2_start = 1'b0, s2_abort = 1'b0, s2_pause = 1'b0, s2_ready = 1'b0;
   logic [31:0]   s2_base = 32'h0;
   logic          s2_valid, s2_last, s2_busy, s2_done;
   logic [287:0]  s2_addr;
   logic [15:0]   s2_row, s2_col;

   win_t          exp_q[$];
   logic [799:0]  cap_b0, cap_b31;
   int            cap_last, cap_beats;

   conv_window_addr_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
      .pause(pause), .out_ready(out_ready), .out_valid(out_valid), .addr_out(addr_out),
      .anchor_row(anchor_row), .anchor_col(anchor_col), .win_last(win_last),
      .busy(busy), .done(done));

   conv_window_addr_gen #(.IMG_W(8), .IMG_H(8), .WIN_W(3), .WIN_H(3), .STRIDE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(s2_start), .abort(s2_abort), .base_addr(s2_base),
      .pause(s2_pause), .out_ready(s2_ready), .out_valid(s2_valid), .addr_out(s2_addr),
      .anchor_row(s2_row), .anchor_col(s2_col), .win_last(s2_last),
      .busy(s2_busy), .done(s2_done));

   // expected lane vector: lane k = anchor + (k % ww) + (k / ww) * iw, modulo 2^32
   function automatic logic [799:0] model_lanes(input logic [31:0] anc, input int ww,
                                                input int nl, input int iw);
      logic [799:0] v;
      v = '0;
      for (int k = 0; k < nl; k++) v[k*32 +: 32] = anc + 32'((k % ww) + (k / ww) * iw);
      return v;
   endfunction

   task automatic test_reset();
      logic [799:0] e;
      e = model_lanes(32'h0, 5, 25, 35);
      #2;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || win_last !== 1'b0 ||
          anchor_row !== 16'd0 || anchor_col !== 16'd0) begin
         $display("FAIL reset_ctrl: valid=%b busy=%b done=%b last=%b row=%0d col=%0d, want all 0",
                  out_valid, busy, done, win_last, anchor_row, anchor_col);
         bad++;
      end
      total++;
      if (addr_out !== e) begin
         $display("FAIL reset_lanes: lane24=%h want %h", addr_out[24*32 +: 32], e[24*32 +: 32]);
         bad++;
      end
      total++;
      if (s2_valid !== 1'b0 || s2_busy !== 1'b0 || s2_done !== 1'b0 || s2_addr[8*32 +: 32] !== 32'd18) begin
         $display("FAIL reset_s2: valid=%b busy=%b done=%b lane8=%0d want 0/0/0/18",
                  s2_valid, s2_busy, s2_done, s2_addr[8*32 +: 32]);
         bad++;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drives one frame on the default instance against the scoreboard.
   // low_pct: chance out_ready is low; pause_pct: chance pause is high;
   // abort_at: beat index at which to abort (-1 = never); spam: random start in RUN.
   task automatic run_frame(input logic [31:0] base, input int low_pct, input int pause_pct,
                            input int abort_at, input bit spam);
      win_t w;
      int beats, cycles;
      logic [799:0] e;
      bit acc;
      exp_q.delete();
      for (int r = 0; r <= 30; r++)
         for (int c = 0; c <= 30; c++) begin
            w.row = r; w.col = c; w.anc = base + 32'(r * 35 + c);
            exp_q.push_back(w);
         end
      @(negedge clk);
      base_addr = base; start = 1'b1; abort = 1'b0; pause = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      base_addr = 32'hDEAD_BEEF;
      beats = 0; cycles = 0; cap_last = -1;
      while (exp_q.size() > 0) begin
         if (cycles >= 20000) begin
            $display("FAIL timeout: beats=%0d after %0d cycles, want %0d beats", beats, cycles, 961);
            bad++; total++;
            break;
         end
         out_ready = ($urandom_range(99) >= low_pct);
         pause     = ($urandom_range(99) < pause_pct);
         start     = spam ? 1'($urandom_range(1)) : 1'b0;
         abort     = (beats == abort_at);
         #1;
         w = exp_q[0];
         e = model_lanes(w.anc, 5, 25, 35);
         total++;
         if (out_valid !== ~pause) begin
            $display("FAIL valid_gate: out_valid=%b pause=%b want %b", out_valid, pause, ~pause);
            bad++;
         end
         total++;
         if (addr_out !== e || anchor_row !== 16'(w.row) || anchor_col !== 16'(w.col)) begin
            $display("FAIL window: beat %0d row=%0d col=%0d lane0=%h want row=%0d col=%0d lane0=%h",
                     beats, anchor_row, anchor_col, addr_out[31:0], w.row, w.col, e[31:0]);
            bad++;
         end
         total++;
         if (win_last !== (exp_q.size() == 1)) begin
            $display("FAIL win_last: beat %0d got %b want %b", beats, win_last, exp_q.size() == 1);
            bad++;
         end
         total++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL run_flags: busy=%b done=%b want 1/0", busy, done);
            bad++;
         end
         if (abort) begin
            @(negedge clk);
            abort = 1'b0; start = 1'b0; out_ready = 1'b0; pause = 1'b0;
            #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
                anchor_row !== 16'd0 || anchor_col !== 16'd0) begin
               $display("FAIL abort: busy=%b done=%b valid=%b row=%0d col=%0d want 0/0/0/0/0",
                        busy, done, out_valid, anchor_row, anchor_col);
               bad++;
            end
            cap_beats = beats;
            return;
         end
         acc = ~pause & out_ready;
         if (acc) begin
            if (beats == 0)  cap_b0  = addr_out;
            if (beats == 31) cap_b31 = addr_out;
            if (win_last)    cap_last = beats;
            w = exp_q.pop_front();
            beats++;
         end
         @(negedge clk);
         cycles++;
      end
      cap_beats = beats;
      // DONE cycle: a start here must be ignored
      start = 1'b1; out_ready = 1'b1; pause = 1'b0;
      #1;
      total++;
      if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL done_pulse: done=%b valid=%b busy=%b want 1/0/1", done, out_valid, busy);
         bad++;
      end
      @(negedge clk);
      start = 1'b0; out_ready = 1'b0;
      #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         $display("FAIL after_done: done=%b busy=%b valid=%b want 0/0/0", done, busy, out_valid);
         bad++;
      end
   endtask

   task automatic test_full_scan();
      run_frame(32'h100, 0, 0, -1, 1'b0);
      total++;
      if (cap_beats !== 961 || cap_last !== 960) begin
         $display("FAIL beat_count: beats=%0d last_at=%0d want 961/960", cap_beats, cap_last);
         bad++;
      end
      total++;
      if (cap_b0[31:0] !== 32'h100 || cap_b0[6*32 +: 32] !== 32'h124) begin
         $display("FAIL beat0: lane0=%h lane6=%h want 100/124", cap_b0[31:0], cap_b0[6*32 +: 32]);
         bad++;
      end
      total++;
      if (cap_b31[31:0] !== 32'h123) begin
         $display("FAIL beat31: anchor=%h want 123", cap_b31[31:0]);
         bad++;
      end
   endtask

   task automatic test_random_handshake();
      run_frame(32'h2000, 30, 30, -1, 1'b1);
      total++;
      if (cap_beats !== 961) begin
         $display("FAIL random_beats: got %0d want 961", cap_beats);
         bad++;
      end
   endtask

   task automatic test_abort();
      run_frame(32'h100, 0, 0, 100, 1'b0);
      total++;
      if (cap_beats !== 100) begin
         $display("FAIL abort_point: aborted at %0d want 100", cap_beats);
         bad++;
      end
      run_frame(32'h0, 10, 10, 40, 1'b0);
      total++;
      if (cap_b0[31:0] !== 32'h0) begin
         $display("FAIL restart: first anchor=%h want 0", cap_b0[31:0]);
         bad++;
      end
   endtask

   task automatic test_wrap();
      run_frame(32'hFFFF_FFF0, 0, 0, 3, 1'b0);
      total++;
      if (cap_b0[24*32 +: 32] !== 32'h0000_0080) begin
         $display("FAIL wrap: lane24=%h want 00000080", cap_b0[24*32 +: 32]);
         bad++;
      end
   endtask

   task automatic test_stride2();
      win_t w;
      logic [799:0] e, got;
      int beats, cycles;
      exp_q.delete();
      for (int r = 0; r <= 4; r += 2)
         for (int c = 0; c <= 4; c += 2) begin
            w.row = r; w.col = c; w.anc = 32'(r * 8 + c);
            exp_q.push_back(w);
         end
      @(negedge clk);
      s2_base = 32'h0; s2_start = 1'b1;
      @(negedge clk);
      s2_start = 1'b0; s2_ready = 1'b1;
      beats = 0; cycles = 0;
      while (exp_q.size() > 0 && cycles < 50) begin
         #1;
         w = exp_q.pop_front();
         e = model_lanes(w.anc, 3, 9, 8);
         got = '0;
         got[287:0] = s2_addr;
         total++;
         if (s2_valid !== 1'b1 || got !== e || s2_row !== 16'(w.row) || s2_col !== 16'(w.col) ||
             s2_last !== (exp_q.size() == 0)) begin
            $display("FAIL s2_window: beat %0d valid=%b row=%0d col=%0d last=%b lane0=%0d want row=%0d col=%0d lane0=%0d",
                     beats, s2_valid, s2_row, s2_col, s2_last, got[31:0], w.row, w.col, e[31:0]);
            bad++;
         end
         if (beats == 8) begin
            total++;
            if (got[31:0] !== 32'd36 || got[8*32 +: 32] !== 32'd54) begin
               $display("FAIL s2_last_addr: anchor=%0d lane8=%0d want 36/54", got[31:0], got[8*32 +: 32]);
               bad++;
            end
         end
         beats++;
         @(negedge clk);
         cycles++;
      end
      s2_ready = 1'b0;
      #1;
      total++;
      if (beats !== 9 || s2_done !== 1'b1 || s2_valid !== 1'b0) begin
         $display("FAIL s2_done: beats=%0d done=%b valid=%b want 9/1/0", beats, s2_done, s2_valid);
         bad++;
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic [799:0] e;
      e = model_lanes(32'h0, 5, 25, 35);
      @(negedge clk);
      base_addr = 32'h500; start = 1'b1;
      @(negedge clk);
      start = 1'b0; out_ready = 1'b1; pause = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || win_last !== 1'b0 ||
          anchor_row !== 16'd0 || anchor_col !== 16'd0 || addr_out !== e) begin
         $display("FAIL async_reset: busy=%b valid=%b row=%0d col=%0d lane0=%h want 0/0/0/0/0",
                  busy, out_valid, anchor_row, anchor_col, addr_out[31:0]);
         bad++;
      end
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_random_handshake();
      test_abort();
      test_wrap();
      test_stride2();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
